// File: rtl/game_round_timer_pkg.sv
// Shared definitions for the round timer and the top-level game state machine.
package game_round_timer_pkg;

  localparam int unsigned GAME_TIME = 60;
  localparam int unsigned SEC_W     = 7;
  localparam int unsigned BCD_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_GAME  = 2'b10,
    ST_SCORE = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    TMR_IDLE    = 2'b00,
    TMR_RUN     = 2'b01,
    TMR_EXPIRED = 2'b10
  } timer_state_e;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd2_t;

  // Compare-ladder conversion for values 0..99; avoids a divider.
  function automatic bcd2_t bin_to_bcd2(input logic [SEC_W-1:0] val);
    bcd2_t            r;
    logic [SEC_W-1:0] rem;
    r.tens = '0;
    rem    = val;
    for (int i = 1; i <= 9; i++) begin
      if (val >= SEC_W'(10 * i)) begin
        r.tens = BCD_W'(i);
        rem    = val - SEC_W'(10 * i);
      end
    end
    r.ones = BCD_W'(rem);
    return r;
  endfunction

endpackage

// File: rtl/bcd2_down_counter.sv
// Two-digit BCD down counter with load and a registered zero flag.
module bcd2_down_counter
  import game_round_timer_pkg::*;
(
  input  logic             pclk,
  input  logic             rst_d,
  input  logic             load,
  input  bcd2_t            load_val,
  input  logic             dec,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             zero
);

  always_ff @(posedge pclk) begin
    if (rst_d) begin
      tens <= '0;
      ones <= '0;
      zero <= 1'b1;
    end else if (load) begin
      tens <= load_val.tens;
      ones <= load_val.ones;
      zero <= (load_val == '0);
    end else if (dec && !zero) begin
      // Ones borrow wraps to 9 and takes one from tens.
      if (ones == BCD_W'(0)) begin
        ones <= BCD_W'(9);
        tens <= tens - BCD_W'(1);
      end else begin
        ones <= ones - BCD_W'(1);
      end
      zero <= (tens == BCD_W'(0)) && (ones == BCD_W'(1));
    end
  end

endmodule

// File: rtl/game_round_timer.sv
// Round countdown for the GAME phase: 1 s prescaler, binary/BCD seconds, expiry and warning.
module game_round_timer
  import game_round_timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 40_000_000,
  parameter int unsigned MAX_TIME  = 99,
  parameter int unsigned WARN_TIME = 10,
  parameter logic [1:0]  GAME_CODE = 2'b10
) (
  input  logic             pclk,
  input  logic             rst_d,
  input  logic [1:0]       state_in,
  input  logic [7:0]       time_in,
  input  logic             pause,
  output logic             end_of_time,
  output logic             sec_tick,
  output logic [SEC_W-1:0] sec_left,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             warn,
  output logic             running
);

  localparam int unsigned      PRE_W    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(CLK_FREQ - 1);
  localparam logic [SEC_W-1:0] MAX_SEC  = SEC_W'(MAX_TIME);
  localparam logic [SEC_W-1:0] WARN_SEC = SEC_W'(WARN_TIME);

  timer_state_e     state, state_n;
  logic [PRE_W-1:0] prescaler, prescaler_n;
  logic [SEC_W-1:0] sec_n, load_sec;
  bcd2_t            load_bcd;
  logic             eot_n, tick_n, running_n, warn_n, bcd_load, bcd_zero, in_game;

  assign in_game  = (state_in == GAME_CODE);
  assign load_sec = (time_in > 8'(MAX_TIME)) ? MAX_SEC : time_in[SEC_W-1:0];
  assign load_bcd = bin_to_bcd2(load_sec);

  bcd2_down_counter u_bcd (
    .pclk     (pclk),
    .rst_d    (rst_d),
    .load     (bcd_load),
    .load_val (load_bcd),
    .dec      (tick_n),
    .tens     (sec_tens),
    .ones     (sec_ones),
    .zero     (bcd_zero)
  );

  // Next-state and next-output logic; priority is exit > pause > tick.
  always_comb begin
    state_n     = state;
    prescaler_n = prescaler;
    sec_n       = sec_left;
    eot_n       = end_of_time;
    tick_n      = 1'b0;
    bcd_load    = 1'b0;
    case (state)
      TMR_IDLE: begin
        if (in_game) begin
          state_n     = TMR_RUN;
          sec_n       = load_sec;
          prescaler_n = '0;
          bcd_load    = 1'b1;
          eot_n       = 1'b0;
        end
      end
      TMR_RUN: begin
        if (!in_game) begin
          state_n = TMR_IDLE;
        end else if (bcd_zero) begin
          state_n = TMR_EXPIRED;
          eot_n   = 1'b1;
        end else if (!pause) begin
          if (prescaler == PRE_TC) begin
            prescaler_n = '0;
            tick_n      = 1'b1;
            sec_n       = sec_left - SEC_W'(1);
            if (sec_left == SEC_W'(1)) begin
              state_n = TMR_EXPIRED;
              eot_n   = 1'b1;
            end
          end else begin
            prescaler_n = prescaler + PRE_W'(1);
          end
        end
      end
      TMR_EXPIRED: begin
        if (!in_game) begin
          state_n = TMR_IDLE;
          eot_n   = 1'b0;
        end
      end
      default: state_n = TMR_IDLE;
    endcase
    running_n = (state_n == TMR_RUN);
    warn_n    = running_n && (sec_n <= WARN_SEC) && (sec_n != '0);
  end

  always_ff @(posedge pclk) begin
    if (rst_d) begin
      state       <= TMR_IDLE;
      prescaler   <= '0;
      end_of_time <= 1'b0;
      sec_tick    <= 1'b0;
      sec_left    <= '0;
      warn        <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= state_n;
      prescaler   <= prescaler_n;
      end_of_time <= eot_n;
      sec_tick    <= tick_n;
      sec_left    <= sec_n;
      warn        <= warn_n;
      running     <= running_n;
    end
  end

endmodule

// File: tb/tb_game_round_timer.sv
// Scoreboard bench for game_round_timer with CLK_FREQ=4.
module tb_game_round_timer;

  logic       pclk = 1'b0;
  logic       rst_d;
  logic [1:0] state_in;
  logic [7:0] time_in;
  logic       pause;
  logic       end_of_time, sec_tick, warn, running;
  logic [6:0] sec_left;
  logic [3:0] sec_tens, sec_ones;

  typedef struct {
    int cyc;
    int sec;
    int tens;
    int ones;
    int warn;
    int eot;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_GAME  = 2'b10;
  localparam logic [1:0] S_SCORE = 2'b11;

  game_round_timer #(
    .CLK_FREQ  (4),
    .MAX_TIME  (99),
    .WARN_TIME (10),
    .GAME_CODE (2'b10)
  ) dut (
    .pclk        (pclk),
    .rst_d       (rst_d),
    .state_in    (state_in),
    .time_in     (time_in),
    .pause       (pause),
    .end_of_time (end_of_time),
    .sec_tick    (sec_tick),
    .sec_left    (sec_left),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .warn        (warn),
    .running     (running)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Expected tick at cycle c leaving s seconds.
  task automatic push_sec(input int c, input int s);
    exp_t e;
    e.cyc  = c;
    e.sec  = s;
    e.tens = s / 10;
    e.ones = s % 10;
    e.warn = (s <= 10 && s != 0) ? 1 : 0;
    e.eot  = (s == 0) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_eot"}, int'(end_of_time), 0);
    chk({tag, "_tick"}, int'(sec_tick), 0);
    chk({tag, "_sec"}, int'(sec_left), 0);
    chk({tag, "_tens"}, int'(sec_tens), 0);
    chk({tag, "_ones"}, int'(sec_ones), 0);
    chk({tag, "_warn"}, int'(warn), 0);
    chk({tag, "_run"}, int'(running), 0);
  endtask

  // Monitor: every sec_tick pops one expected entry.
  initial begin
    forever begin
      @(negedge pclk);
      if (sec_tick === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_tick", int'(sec_left), -1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("tick_cycle", cyc, e.cyc);
          chk("tick_sec", int'(sec_left), e.sec);
          chk("tick_tens", int'(sec_tens), e.tens);
          chk("tick_ones", int'(sec_ones), e.ones);
          chk("tick_warn", int'(warn), e.warn);
          chk("tick_eot", int'(end_of_time), e.eot);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int exp_tens[10] = '{9, 9, 9, 9, 9, 9, 9, 9, 9, 8};
    int exp_ones[10] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 9};

    rst_d    = 1'b1;
    state_in = S_IDLE;
    time_in  = 8'd0;
    pause    = 1'b0;
    step(2);
    chk_all_zero("reset");
    rst_d = 1'b0;
    step(1);

    // Basic countdown from 3.
    state_in = S_GAME;
    time_in  = 8'd3;
    t0 = cyc;
    push_sec(t0 + 5, 2);
    push_sec(t0 + 9, 1);
    push_sec(t0 + 13, 0);
    step(1);
    chk("load3_run", int'(running), 1);
    chk("load3_sec", int'(sec_left), 3);
    chk("load3_ones", int'(sec_ones), 3);
    step(12);
    chk("exp3_eot", int'(end_of_time), 1);
    chk("exp3_run", int'(running), 0);
    chk("exp3_sec", int'(sec_left), 0);
    state_in = S_IDLE;
    step(1);
    chk("exp3_clear", int'(end_of_time), 0);

    // Saturated load and ones borrow 90 -> 89.
    state_in = S_GAME;
    time_in  = 8'd120;
    t0 = cyc;
    for (int k = 1; k <= 10; k++) push_sec(t0 + 1 + 4 * k, 99 - k);
    step(1);
    chk("sat_sec", int'(sec_left), 99);
    chk("sat_tens", int'(sec_tens), 9);
    chk("sat_ones", int'(sec_ones), 9);
    chk("sat_warn", int'(warn), 0);
    step(36);
    chk("borrow_tens90", int'(sec_tens), exp_tens[8]);
    chk("borrow_ones90", int'(sec_ones), exp_ones[8]);
    step(4);
    chk("borrow_tens89", int'(sec_tens), exp_tens[9]);
    chk("borrow_ones89", int'(sec_ones), exp_ones[9]);
    state_in = S_IDLE;
    step(1);
    chk("sat_exit_run", int'(running), 0);
    chk("sat_exit_sec", int'(sec_left), 89);

    // Pause after two prescaler counts preserves the partial second.
    state_in = S_GAME;
    time_in  = 8'd5;
    t0 = cyc;
    push_sec(t0 + 15, 4);
    step(3);
    pause = 1'b1;
    step(10);
    chk("pause_sec", int'(sec_left), 5);
    chk("pause_warn", int'(warn), 1);
    pause = 1'b0;
    step(2);
    chk("pause_tick_sec", int'(sec_left), 4);
    state_in = S_IDLE;
    step(1);
    chk("pause_exit_run", int'(running), 0);

    // Leaving GAME mid-run at 25 holds the display, no expiry.
    state_in = S_GAME;
    time_in  = 8'd27;
    t0 = cyc;
    push_sec(t0 + 5, 26);
    push_sec(t0 + 9, 25);
    step(9);
    state_in = S_SCORE;
    step(1);
    chk("score_run", int'(running), 0);
    chk("score_sec", int'(sec_left), 25);
    step(10);
    chk("score_eot", int'(end_of_time), 0);
    chk("score_hold_sec", int'(sec_left), 25);
    chk("score_tens", int'(sec_tens), 2);
    chk("score_ones", int'(sec_ones), 5);
    state_in = S_GAME;
    time_in  = 8'd7;
    step(1);
    chk("reload_sec", int'(sec_left), 7);
    chk("reload_run", int'(running), 1);
    state_in = S_IDLE;
    step(1);

    // Zero load expires one cycle after load with no tick.
    state_in = S_GAME;
    time_in  = 8'd0;
    step(1);
    chk("zero_load_run", int'(running), 1);
    chk("zero_load_eot", int'(end_of_time), 0);
    step(1);
    chk("zero_eot", int'(end_of_time), 1);
    chk("zero_run", int'(running), 0);
    chk("zero_tick", int'(sec_tick), 0);
    state_in = S_IDLE;
    step(1);
    chk("zero_clear", int'(end_of_time), 0);

    // Warning window from 10 down to 1.
    state_in = S_GAME;
    time_in  = 8'd12;
    t0 = cyc;
    for (int k = 1; k <= 12; k++) push_sec(t0 + 1 + 4 * k, 12 - k);
    step(1);
    chk("warn12", int'(warn), 0);
    chk("warn12_tens", int'(sec_tens), 1);
    step(4);
    chk("warn11", int'(warn), 0);
    step(4);
    chk("warn10", int'(warn), 1);
    chk("warn10_sec", int'(sec_left), 10);
    step(40);
    chk("warn0", int'(warn), 0);
    chk("warn0_eot", int'(end_of_time), 1);
    state_in = S_IDLE;
    step(1);

    // Reset during RUN clears everything on the next edge.
    state_in = S_GAME;
    time_in  = 8'd12;
    t0 = cyc;
    for (int k = 1; k <= 4; k++) push_sec(t0 + 1 + 4 * k, 12 - k);
    step(19);
    rst_d    = 1'b1;
    state_in = S_IDLE;
    step(1);
    chk_all_zero("midrst");
    rst_d = 1'b0;
    step(3);

    chk("pending_ticks", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
